// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron and its configuration loader:
// field widths, CFG byte layout, loader states and the frame checksum.
package lif_pkg;

  localparam int W_WEIGHT = 3;
  localparam int W_LEAK   = 2;
  localparam int W_THR    = 8;

  // Bit positions of each field's MSB inside the CFG byte.
  localparam int WA_MSB = 7;
  localparam int WB_MSB = 4;
  localparam int LK_MSB = 1;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_THMIN,
    ST_THMAX,
    ST_CSUM
  } load_state_t;

  function automatic logic [7:0] frame_csum(input logic [7:0] cfg,
                                            input logic [7:0] thmin,
                                            input logic [7:0] thmax);
    return cfg ^ thmin ^ thmax;
  endfunction

endpackage

// File: rtl/lif_frame_timer.sv
// Saturating inactivity counter: expired pulses on the idle cycle whose
// edge brings the count up to TIMEOUT_CYC.
module lif_frame_timer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYC);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (run && count != LIMIT) begin
      count <= count + 1'b1;
    end
  end

  assign expired = run && !clr && (count == LIMIT - 1'b1);

endmodule

// File: rtl/lif_param_loader.sv
// Byte-serial parameter loader: validates HEADER/CFG/THMIN/THMAX/CSUM
// frames and commits the whole parameter set atomically on CSUM.
module lif_param_loader
  import lif_pkg::*;
#(
  parameter logic [7:0]       HEADER      = HEADER_DEFAULT,
  parameter int               TIMEOUT_CYC = 16,
  parameter logic [W_THR-1:0] RST_THR_MIN = 8'd20,
  parameter logic [W_THR-1:0] RST_THR_MAX = 8'd200
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          byte_in,
  input  logic                byte_valid,
  input  logic                params_clear,
  output logic [W_WEIGHT-1:0] weight_a,
  output logic [W_WEIGHT-1:0] weight_b,
  output logic [W_LEAK-1:0]   leak_config,
  output logic [W_THR-1:0]    threshold_min,
  output logic [W_THR-1:0]    threshold_max,
  output logic                params_ready,
  output logic                load_busy,
  output logic                load_error
);

  load_state_t state, next_state;

  logic [7:0]       shadow_cfg;
  logic [W_THR-1:0] shadow_thmin;
  logic [W_THR-1:0] shadow_thmax;

  logic load_cfg, load_thmin, load_thmax;
  logic commit, set_error, clear_error, discard;
  logic timer_run, timer_expired;

  assign timer_run = (state != ST_IDLE) && !byte_valid;

  lif_frame_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (byte_valid),
    .run    (timer_run),
    .expired(timer_expired)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    next_state  = state;
    load_cfg    = 1'b0;
    load_thmin  = 1'b0;
    load_thmax  = 1'b0;
    commit      = 1'b0;
    set_error   = 1'b0;
    clear_error = 1'b0;
    discard     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (byte_valid && byte_in == HEADER) begin
          next_state  = ST_CFG;
          clear_error = 1'b1;
        end
      end
      ST_CFG: begin
        if (byte_valid) begin
          load_cfg   = 1'b1;
          next_state = ST_THMIN;
        end
      end
      ST_THMIN: begin
        if (byte_valid) begin
          load_thmin = 1'b1;
          next_state = ST_THMAX;
        end
      end
      ST_THMAX: begin
        if (byte_valid) begin
          load_thmax = 1'b1;
          next_state = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (byte_valid) begin
          next_state = ST_IDLE;
          if (byte_in == frame_csum(shadow_cfg, shadow_thmin, shadow_thmax) &&
              shadow_thmin <= shadow_thmax) begin
            commit = 1'b1;
          end else begin
            set_error = 1'b1;
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase

    // The timer only expires on a cycle with no byte, so it never races a transition.
    if (timer_expired) begin
      next_state = ST_IDLE;
      set_error  = 1'b1;
      discard    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: the shadow registers are reset like any other state so that an
  // aborted or fresh frame never starts from unknown contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_cfg   <= '0;
      shadow_thmin <= '0;
      shadow_thmax <= '0;
    end else if (discard) begin
      shadow_cfg   <= '0;
      shadow_thmin <= '0;
      shadow_thmax <= '0;
    end else begin
      if (load_cfg)   shadow_cfg   <= byte_in;
      if (load_thmin) shadow_thmin <= byte_in;
      if (load_thmax) shadow_thmax <= byte_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      weight_a      <= '0;
      weight_b      <= '0;
      leak_config   <= '0;
      threshold_min <= RST_THR_MIN;
      threshold_max <= RST_THR_MAX;
    end else if (commit) begin
      weight_a      <= shadow_cfg[WA_MSB -: W_WEIGHT];
      weight_b      <= shadow_cfg[WB_MSB -: W_WEIGHT];
      leak_config   <= shadow_cfg[LK_MSB -: W_LEAK];
      threshold_min <= shadow_thmin;
      threshold_max <= shadow_thmax;
    end
  end

  // A commit on the same edge as params_clear leaves params_ready set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      params_ready <= 1'b0;
      load_error   <= 1'b0;
    end else begin
      if (commit)            params_ready <= 1'b1;
      else if (params_clear) params_ready <= 1'b0;

      if (set_error)        load_error <= 1'b1;
      else if (clear_error) load_error <= 1'b0;
    end
  end

  assign load_busy = (state != ST_IDLE);

endmodule

// File: doc/lif_param_loader.md
Name: lif_param_loader

Overview:
Upstream configuration stage for lif_neuron. It receives a byte-serial configuration frame, validates the header, checksum and threshold ordering, and then atomically commits weight_a, weight_b, leak_config, threshold_min and threshold_max. It drives params_ready to the neuron. The neuron never sees a partially loaded or invalid parameter set.

Parameters:
HEADER, 8'hA5, frame start byte.
TIMEOUT_CYC, 16, maximum idle cycles between bytes inside a frame before abort.
RST_THR_MIN, 8'd20, threshold_min value after reset.
RST_THR_MAX, 8'd200, threshold_max value after reset.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
byte_in  in  8  configuration byte
byte_valid  in  1  byte_in is valid this cycle; accepted every cycle (no backpressure)
params_clear  in  1  synchronous drop of params_ready
weight_a  out  3  committed weight A
weight_b  out  3  committed weight B
leak_config  out  2  committed leak select
threshold_min  out  8  committed minimum threshold
threshold_max  out  8  committed maximum threshold
params_ready  out  1  a valid set has been committed since reset or clear
load_busy  out  1  frame in progress (state != IDLE)
load_error  out  1  sticky error flag; cleared when the next HEADER is accepted

Behaviour:
- Reset, asynchronous, active-high, overrides all other inputs:
  - state=IDLE; weight_a=0; weight_b=0; leak_config=0.
  - threshold_min=RST_THR_MIN; threshold_max=RST_THR_MAX.
  - params_ready=0; load_busy=0; load_error=0; shadow registers=0; timer=0.
- Frame format: HEADER, CFG, THMIN, THMAX, CSUM.
  - CFG = {weight_a[2:0], weight_b[2:0], leak_config[1:0]}, MSB first.
  - CSUM = CFG ^ THMIN ^ THMAX (8-bit XOR).
- States: IDLE -> S_CFG -> S_THMIN -> S_THMAX -> S_CSUM -> IDLE.
  - Each transition happens only on a cycle with byte_valid=1.
- IDLE:
  - byte_valid && byte_in==HEADER: go to S_CFG, clear load_error.
  - Any other byte: ignored, no error.
- S_CFG, S_THMIN, S_THMAX: store byte_in into the matching shadow register and advance. A HEADER value in these states is data; there is no resync.
- S_CSUM, on byte_valid:
  - Commit condition: byte_in == XOR of the shadows AND shadow_thmin <= shadow_thmax.
  - Commit: all five outputs update on the same clock edge that accepts CSUM, so outputs are valid the cycle after CSUM. params_ready<=1. Return to IDLE.
  - Failure (either check): outputs unchanged, params_ready unchanged, load_error<=1, return to IDLE.
- Timeout:
  - Timer is reset to 0 on every accepted byte and increments while state!=IDLE && !byte_valid.
  - When the timer reaches TIMEOUT_CYC: go to IDLE, load_error<=1, shadows discarded, outputs unchanged.
  - Timer saturates and does not wrap.
- params_clear: params_ready<=0 on the next edge. Frame state and committed values are untouched.
  - If params_clear and a valid commit occur on the same edge, commit wins: params_ready=1.
- Recommit while params_ready=1: outputs switch atomically in one cycle, and params_ready stays 1 with no glitch low.
- load_busy is 1 in every non-IDLE state and combinationally mirrors the state.
- Threshold values are 8-bit unsigned. The comparison is unsigned, and equality is legal.
- End-to-end latency: HEADER to params_ready high is 5 accepted bytes + 1 edge. The minimum is 5 cycles with back-to-back bytes.

Decomposition:
- Shared package lif_pkg:
  - loader state enum.
  - HEADER default.
  - CFG field bit positions (WA_MSB=7, WB_MSB=4, LK_MSB=1).
  - Widths W_WEIGHT=3, W_LEAK=2, W_THR=8.
  - lif_neuron uses the same width constants.
- One sub-module, lif_frame_timer: saturating inactivity counter with inputs clr and run, output expired. Everything else stays in lif_param_loader.

Test Plan:
- Valid frame back-to-back A5,6E,10,40,3E -> cycle after 3E:
  - weight_a=3, weight_b=3, leak_config=2, threshold_min=0x10, threshold_max=0x40.
  - params_ready=1, load_error=0, load_busy=0.
- Bad checksum A5,6E,10,40,3F -> outputs remain at reset values (20/200, weights 0), params_ready=0, load_error=1. A following valid frame clears load_error at its HEADER and commits.
- Ordering violation A5,6E,50,40,(6E^50^40=7E) -> rejected with load_error=1, outputs unchanged. The equal case A5,00,30,30,00 -> commits with threshold_min=threshold_max=0x30.
- Timeout: A5,6E, then byte_valid low for 16 cycles -> IDLE and load_error=1. Later bytes 10,40,3E without a HEADER are ignored and params_ready stays 0.
- Recommit and clear:
  - After a valid commit, send A5,FF,01,FE,(FF^01^FE=00) -> outputs change in one cycle to 7/7/3/0x01/0xFE, params_ready held at 1.
  - params_clear pulse -> params_ready=0, values retained.
  - params_clear on the same edge as a CSUM commit -> params_ready=1.
- Async reset asserted mid-frame, after A5,6E,10 and between clock edges -> all outputs return to reset values immediately. After deassert, a full valid frame commits normally.
